sd_dma_engine: RTL and testbench

Parametrised successor to the single-channel SD DMA controller. It moves whole SD blocks between RAM and the SD card interface, one 32-bit word per `mem_ready_set` beat, pausing between blocks until the SD side signals ready. It adds a configurable block size, a multi-entry pending-beat credit queue, start-time argument checking, software abort, an interrupt output, and SD-side data/handshake ports. It sits behind the SD MMIO window, between the CPU register file and the memory/SD arbiters.

---
 rtl/sd_dma_engine.sv | 193 +++++++++++++++++++
 tb/tb_sd_dma_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dma_engine.sv
// Block-oriented DMA between RAM and the SD interface: credit queue, argument checks, abort, irq.
// Optional byte reversal of data in both directions when SD_DMA_BYTE_SWAP_EN is defined.
module sd_dma_engine #(
  parameter int unsigned BLOCK_WORDS = 128,
  parameter int unsigned PEND_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_start_addr,
  input  logic [31:0]       sd_block_start_addr,
  input  logic [31:0]       num_blocks,
  input  logic [31:0]       ctrl_data,
  input  logic              ctrl_write,
  input  logic              status_clear,
  input  logic              mem_ready_set,
  input  logic              sd_ready_set,
  input  logic [31:0]       mem_data_in,
  input  logic [31:0]       sd_data_in,
  output logic [31:0]       ctrl,
  output logic [31:0]       status,
  output logic [31:0]       error_code,
  output logic              irq,
  output logic [ADDR_W-1:0] mem_request_addr_out,
  output logic [31:0]       mem_request_data,
  output logic              mem_request_read,
  output logic              mem_request_write,
  output logic [31:0]       sd_data_out,
  output logic              sd_data_valid,
  output logic [31:0]       sd_block_addr_out,
  output logic              sd_block_req
);

  localparam int unsigned     CntW     = $clog2(BLOCK_WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(BLOCK_WORDS - 1);
  localparam logic [3:0]      PendMax  = 4'(PEND_DEPTH);

  typedef enum logic [1:0] {StIdle, StXfer, StBwait} state_e;

  state_e            state_q;
  logic              dir_q, irq_en_q, swap_q, done_q, err_q;
  logic [2:0]        err_code_q;
  logic [3:0]        credits_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sd_blk_q, blocks_left_q, mem_wdata_q, sd_rdata_q;
  logic [CntW-1:0]   word_cnt_q;
  logic              sd_valid_q, blk_req_q;

  logic        start, abort, beat, use_credit, last_word, final_block, busy;
  logic        swap_in;
  logic [31:0] sd_word, mem_word;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl_data[31:4];

`ifdef SD_DMA_BYTE_SWAP_EN
  assign swap_in  = ctrl_data[4];
  assign sd_word  = swap_q ? {sd_data_in[7:0], sd_data_in[15:8], sd_data_in[23:16],
                              sd_data_in[31:24]} : sd_data_in;
  assign mem_word = swap_q ? {mem_data_in[7:0], mem_data_in[15:8], mem_data_in[23:16],
                              mem_data_in[31:24]} : mem_data_in;
`else
  assign swap_in  = 1'b0;
  assign sd_word  = sd_data_in;
  assign mem_word = mem_data_in;
`endif

  always_comb begin
    start       = ctrl_write & ctrl_data[0];
    abort       = ctrl_write & ctrl_data[3] & ~ctrl_data[0];
    // A live pulse is consumed before any queued credit.
    beat        = mem_ready_set | (credits_q != 4'd0);
    use_credit  = ~mem_ready_set & (credits_q != 4'd0);
    last_word   = word_cnt_q == LastWord;
    final_block = blocks_left_q == 32'd1;
    busy        = state_q != StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      dir_q         <= 1'b0;
      irq_en_q      <= 1'b0;
      swap_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 3'd0;
      credits_q     <= 4'd0;
      addr_q        <= '0;
      sd_blk_q      <= 32'd0;
      blocks_left_q <= 32'd0;
      mem_wdata_q   <= 32'd0;
      sd_rdata_q    <= 32'd0;
      word_cnt_q    <= '0;
      sd_valid_q    <= 1'b0;
      blk_req_q     <= 1'b0;
    end else begin
      sd_valid_q <= 1'b0;
      blk_req_q  <= 1'b0;
      // Clear first so that a DONE/ERR set later in this cycle takes precedence.
      if (status_clear) begin
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        err_code_q <= 3'd0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_blocks == 32'd0) begin
              err_q      <= 1'b1;
              err_code_q <= 3'd1;
            end else if (mem_start_addr[1:0] != 2'b00) begin
              err_q      <= 1'b1;
              err_code_q <= 3'd2;
            end else begin
              dir_q         <= ctrl_data[1];
              irq_en_q      <= ctrl_data[2];
              swap_q        <= swap_in;
              addr_q        <= mem_start_addr;
              sd_blk_q      <= sd_block_start_addr;
              blocks_left_q <= num_blocks;
              word_cnt_q    <= '0;
              credits_q     <= 4'd0;
              done_q        <= 1'b0;
              state_q       <= StXfer;
            end
          end
        end
        StXfer: begin
          if (abort) begin
            state_q    <= StIdle;
            err_q      <= 1'b1;
            err_code_q <= 3'd3;
            credits_q  <= 4'd0;
          end else if (beat) begin
            if (use_credit) credits_q <= credits_q - 4'd1;
            addr_q     <= addr_q + ADDR_W'(4);
            word_cnt_q <= word_cnt_q + 1'b1;
            if (dir_q) begin
              sd_rdata_q <= mem_word;
              sd_valid_q <= 1'b1;
            end else begin
              mem_wdata_q <= sd_word;
            end
            if (last_word) begin
              if (final_block) begin
                state_q   <= StIdle;
                done_q    <= 1'b1;
                credits_q <= 4'd0;
              end else begin
                blk_req_q     <= 1'b1;
                sd_blk_q      <= sd_blk_q + 32'd1;
                blocks_left_q <= blocks_left_q - 32'd1;
                state_q       <= StBwait;
              end
            end
          end
        end
        StBwait: begin
          if (abort) begin
            state_q    <= StIdle;
            err_q      <= 1'b1;
            err_code_q <= 3'd3;
            credits_q  <= 4'd0;
          end else if (mem_ready_set && credits_q == PendMax) begin
            state_q    <= StIdle;
            err_q      <= 1'b1;
            err_code_q <= 3'd4;
            credits_q  <= 4'd0;
          end else begin
            if (mem_ready_set) credits_q <= credits_q + 4'd1;
            if (sd_ready_set) state_q <= StXfer;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl                 = {27'b0, swap_q, 1'b0, irq_en_q, dir_q, busy};
  assign status               = {24'b0, credits_q, 1'b0, err_q, done_q, busy};
  assign error_code           = {29'b0, err_code_q};
  assign irq                  = irq_en_q & (done_q | err_q);
  assign mem_request_addr_out = addr_q;
  assign mem_request_data     = mem_wdata_q;
  assign mem_request_read     = (state_q == StXfer) & dir_q;
  assign mem_request_write    = (state_q == StXfer) & ~dir_q;
  assign sd_data_out          = sd_rdata_q;
  assign sd_data_valid        = sd_valid_q;
  assign sd_block_addr_out    = sd_blk_q;
  assign sd_block_req         = blk_req_q;

endmodule

// File: tb/tb_sd_dma_engine.sv
// Self-checking bench for sd_dma_engine: word-count based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized transfers and a mid-run reset.
module tb_sd_dma_engine;
  localparam int unsigned BW = 128;
  localparam int unsigned PD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_start_addr = '0, sd_block_start_addr = '0, num_blocks = '0;
  logic [31:0] ctrl_data = '0, mem_data_in = '0, sd_data_in = '0;
  logic        ctrl_write = 1'b0, status_clear = 1'b0, mem_ready_set = 1'b0, sd_ready_set = 1'b0;
  logic [31:0] ctrl, status, error_code, mem_request_addr_out, mem_request_data;
  logic [31:0] sd_data_out, sd_block_addr_out;
  logic        irq, mem_request_read, mem_request_write, sd_data_valid, sd_block_req;

  always #5 clk = ~clk;

  sd_dma_engine #(.BLOCK_WORDS(BW), .PEND_DEPTH(PD), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_start_addr(mem_start_addr),
    .sd_block_start_addr(sd_block_start_addr), .num_blocks(num_blocks), .ctrl_data(ctrl_data),
    .ctrl_write(ctrl_write), .status_clear(status_clear), .mem_ready_set(mem_ready_set),
    .sd_ready_set(sd_ready_set), .mem_data_in(mem_data_in), .sd_data_in(sd_data_in),
    .ctrl(ctrl), .status(status), .error_code(error_code), .irq(irq),
    .mem_request_addr_out(mem_request_addr_out), .mem_request_data(mem_request_data),
    .mem_request_read(mem_request_read), .mem_request_write(mem_request_write),
    .sd_data_out(sd_data_out), .sd_data_valid(sd_data_valid),
    .sd_block_addr_out(sd_block_addr_out), .sd_block_req(sd_block_req)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: progress is a running word count, expectations derived arithmetically.
  bit          m_busy, m_waiting, m_dir, m_irq_en, m_done, m_err, m_breq, m_valid;
  int unsigned m_code, m_credits;
  longint      m_words, m_total;
  bit [31:0]   m_base, m_sd_base, m_mdata, m_sdout;

  task automatic model_reset();
    m_busy = 0; m_waiting = 0; m_dir = 0; m_irq_en = 0; m_done = 0; m_err = 0;
    m_breq = 0; m_valid = 0; m_code = 0; m_credits = 0; m_words = 0; m_total = 0;
    m_base = 0; m_sd_base = 0; m_mdata = 0; m_sdout = 0;
  endtask

  task automatic fail_with(input int unsigned c);
    m_err = 1; m_code = c;
  endtask

  task automatic model_step();
    bit start, abort, beat;
    start = ctrl_write && ctrl_data[0];
    abort = ctrl_write && ctrl_data[3] && !ctrl_data[0];
    m_breq = 0; m_valid = 0;
    if (status_clear) begin m_done = 0; m_err = 0; m_code = 0; end
    if (!m_busy) begin
      if (start) begin
        if (num_blocks == 0) fail_with(1);
        else if (mem_start_addr[1:0] != 2'b00) fail_with(2);
        else begin
          m_busy = 1; m_waiting = 0; m_dir = ctrl_data[1]; m_irq_en = ctrl_data[2];
          m_base = mem_start_addr; m_sd_base = sd_block_start_addr; m_words = 0;
          m_total = longint'(num_blocks) * BW; m_credits = 0; m_done = 0;
        end
      end
    end else if (abort) begin
      m_busy = 0; m_credits = 0; fail_with(3);
    end else if (m_waiting) begin
      if (mem_ready_set) begin
        if (m_credits == PD) begin m_busy = 0; m_credits = 0; fail_with(4); end
        else m_credits++;
      end
      if (m_busy && sd_ready_set) m_waiting = 0;
    end else begin
      beat = mem_ready_set || (m_credits > 0);
      if (beat) begin
        if (!mem_ready_set) m_credits--;
        m_words++;
        if (m_dir) begin m_sdout = mem_data_in; m_valid = 1; end
        else m_mdata = sd_data_in;
        if (m_words == m_total) begin m_busy = 0; m_done = 1; m_credits = 0; end
        else if (m_words % BW == 0) begin m_waiting = 1; m_breq = 1; end
      end
    end
  endtask

  function automatic logic [31:0] exp_addr();
    return m_base + 32'(m_words * 4);
  endfunction

  function automatic logic [31:0] exp_blk();
    if (m_total != 0 && m_words == m_total) return m_sd_base + 32'(m_words / BW) - 32'd1;
    return m_sd_base + 32'(m_words / BW);
  endfunction

  task automatic compare();
    bit xfer;
    xfer = m_busy && !m_waiting;
    check("ctrl", ctrl, {29'b0, m_irq_en, m_dir, m_busy});
    check("status", status, {24'b0, 4'(m_credits), 1'b0, m_err, m_done, m_busy});
    check("error_code", error_code, m_code);
    check("irq", 32'(irq), 32'(m_irq_en && (m_done || m_err)));
    check("addr", mem_request_addr_out, exp_addr());
    check("mem_data", mem_request_data, m_mdata);
    check("mem_read", 32'(mem_request_read), 32'(xfer && m_dir));
    check("mem_write", 32'(mem_request_write), 32'(xfer && !m_dir));
    check("sd_data", sd_data_out, m_sdout);
    check("sd_valid", 32'(sd_data_valid), 32'(m_valid));
    check("sd_blk_addr", sd_block_addr_out, exp_blk());
    check("sd_blk_req", 32'(sd_block_req), 32'(m_breq));
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && cmp_en) compare();
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    ctrl_data = v; ctrl_write = 1'b1;
    tick();
    ctrl_write = 1'b0; ctrl_data = '0;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] nb, input logic [31:0] sb,
                       input logic [31:0] cv);
    mem_start_addr = a; num_blocks = nb; sd_block_start_addr = sb;
    wr_ctrl(cv);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready_set = 1'b1; sd_data_in = $urandom; mem_data_in = $urandom;
      tick();
    end
    mem_ready_set = 1'b0;
  endtask

  task automatic clear();
    status_clear = 1'b1; tick(); status_clear = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();
    check("reset ctrl", ctrl, 32'h0);
    check("reset status", status, 32'h0);
    check("reset addr", mem_request_addr_out, 32'h0);

    // DIR=0, one block at 0x1000
    start(32'h1000, 32'd1, 32'd5, 32'h1);
    check("t1 busy", 32'(status[0]), 32'd1);
    check("t1 write", 32'(mem_request_write), 32'd1);
    check("t1 read", 32'(mem_request_read), 32'd0);
    beats(BW);
    check("t1 status", status, 32'h2);
    check("t1 addr", mem_request_addr_out, 32'h1200);
    check("t1 model addr", exp_addr(), 32'h1200);

    // DIR=1, two blocks at 0x2000, credits queued in the gap
    start(32'h2000, 32'd2, 32'd100, 32'h7);
    beats(BW);
    check("t2 blk_req", 32'(sd_block_req), 32'd1);
    check("t2 blk addr", sd_block_addr_out, 32'd101);
    beats(3);
    check("t2 blk_req once", 32'(sd_block_req), 32'd0);
    check("t2 held addr", mem_request_addr_out, 32'h2200);
    check("t2 credits", 32'(status[7:4]), 32'd3);
    sd_ready_set = 1'b1; tick(); sd_ready_set = 1'b0;
    repeat (3) tick();
    check("t2 drained addr", mem_request_addr_out, 32'h220C);
    beats(BW - 3);
    check("t2 done", status, 32'h2);
    check("t2 irq", 32'(irq), 32'd1);
    check("t2 model blk", exp_blk(), 32'd101);

    // Credit overflow
    clear();
    start(32'h3000, 32'd2, 32'd0, 32'h7);
    beats(BW);
    beats(PD + 1);
    check("t3 code", error_code, 32'd4);
    check("t3 status", status, 32'h4);
    check("t3 irq", 32'(irq), 32'd1);

    // Bad start arguments
    clear();
    start(32'h1000, 32'd0, 32'd0, 32'h1);
    check("t4 code zero", error_code, 32'd1);
    check("t4 busy zero", 32'(status[0]), 32'd0);
    clear();
    start(32'h1002, 32'd1, 32'd0, 32'h1);
    check("t4 code misalign", error_code, 32'd2);
    check("t4 busy misalign", 32'(status[0]), 32'd0);

    // Abort, and status_clear while busy
    clear();
    start(32'h4000, 32'd3, 32'd0, 32'h1);
    beats(10);
    wr_ctrl(32'h8);
    check("t5 busy", 32'(status[0]), 32'd0);
    check("t5 code", error_code, 32'd3);
    check("t5 addr", mem_request_addr_out, 32'h4028);
    start(32'h5000, 32'd1, 32'd0, 32'h1);
    clear();
    check("t5 busy kept", 32'(status[0]), 32'd1);
    check("t5 code cleared", error_code, 32'd0);
    wr_ctrl(32'h8);

    // DIR=1 data path
    clear();
    start(32'h6000, 32'd1, 32'd0, 32'h3);
    mem_data_in = 32'h12345678; mem_ready_set = 1'b1;
    tick();
    mem_ready_set = 1'b0;
    check("t6 sd_data", sd_data_out, 32'h12345678);
    check("t6 valid", 32'(sd_data_valid), 32'd1);
    tick();
    check("t6 valid drop", 32'(sd_data_valid), 32'd0);
    wr_ctrl(32'h8);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      int budget;
      logic [31:0] a, cv;
      if ($urandom_range(0, 3) == 0) clear();
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      cv = ($urandom & 32'hFFFF_FFF0) | 32'h1 | ($urandom_range(0, 1) << 1)
           | ($urandom_range(0, 1) << 2);
      start(a, 32'($urandom_range(0, 3)), $urandom, cv);
      budget = 4000;
      while (status[0] && budget > 0) begin
        mem_ready_set = m_waiting ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
        sd_ready_set  = $urandom_range(0, 7) == 0;
        sd_data_in    = $urandom;
        mem_data_in   = $urandom;
        status_clear  = $urandom_range(0, 39) == 0;
        ctrl_write    = 1'b0;
        if ($urandom_range(0, 99) == 0) begin
          ctrl_write = 1'b1; ctrl_data = $urandom | 32'h1;
        end else if ($urandom_range(0, 1499) == 0) begin
          ctrl_write = 1'b1; ctrl_data = 32'h8;
        end
        tick();
        budget--;
      end
      mem_ready_set = 1'b0; sd_ready_set = 1'b0; status_clear = 1'b0; ctrl_write = 1'b0;
      if (budget == 0) begin
        check("random timeout", 32'(status[0]), 32'd0);
        wr_ctrl(32'h8);
      end
      tick();
    end

    // Reset mid-transfer
    clear();
    start(32'h7000, 32'd2, 32'd9, 32'h3);
    beats(50);
    #2 rst_n = 1'b0;
    tick();
    check("rst status", status, 32'h0);
    check("rst addr", mem_request_addr_out, 32'h0);
    check("rst ctrl", ctrl, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("post rst status", status, 32'h0);
    check("post rst blk", sd_block_addr_out, 32'h0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
